// File: rtl/sha2_eddsa_pkg.sv
// sha2_eddsa_pkg: shared constants, FSM encoding and byte pad helper for the SHA-2 pad writer
package sha2_eddsa_pkg;
  localparam int BLOCK_WORDS = 16;
  localparam int LEN_ADDR_HI = 14;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {LOAD, PAD, LEN, HOLD} state_e;

  // Word of `bytes` bytes right-aligned in d, MSB-first: keep bytes below n, 0x80 at n, zeros after
  function automatic logic [63:0] pad_word(input logic [63:0] d, input logic [3:0] bytes, input logic [3:0] n);
    logic [63:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(bytes)) begin
        s = (int'(bytes) - 1 - i) * 8;
        r[s+:8] = i < int'(n) ? d[s+:8] : i == int'(n) ? PAD_BYTE : 8'h00;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/sha2_pad_writer_eddsa.sv
// sha2_pad_writer_eddsa: streams message words into a 16-word RAM block and appends SHA-2 padding and length
module sha2_pad_writer_eddsa
  import sha2_eddsa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BYTES = WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  input  logic [$clog2(BYTES):0]   in_bytes,
  output logic                     mem_en_write,
  output logic [3:0]               mem_addr_write,
  output logic [WIDTH-1:0]         mem_data_in,
  output logic                     block_valid,
  output logic                     block_last,
  input  logic                     block_done
);
  state_e state_q, state_d, resume_q, resume_d, follow;
  logic [3:0] addr_q, addr_d, maddr_q, maddr_d, n;
  logic [63:0] bitlen_q, bitlen_d;
  logic [WIDTH-1:0] data_q, data_d, pw, len_hi, len_lo;
  logic pad_done_q, pad_done_d, last_q, last_d, valid_q, valid_d, en_q, en_d;

  always_comb begin
    n = state_q != LOAD ? 4'd0 : in_last ? 4'(in_bytes) : 4'(BYTES);
    pw = WIDTH'(pad_word(state_q == LOAD ? 64'(in_data) : 64'd0, 4'(BYTES), n));
    len_hi = (WIDTH == 32) ? WIDTH'(bitlen_q >> 32) : '0;
    len_lo = bitlen_q[WIDTH-1:0];
    state_d = state_q;
    resume_d = resume_q;
    addr_d = addr_q;
    bitlen_d = bitlen_q;
    pad_done_d = pad_done_q;
    last_d = last_q;
    en_d = 1'b0;
    maddr_d = addr_q;
    data_d = '0;
    valid_d = state_q == HOLD && !en_q && !block_done;
    case (state_q)
      LOAD: if (in_valid) begin
        en_d = 1'b1;
        data_d = pw;
        bitlen_d = bitlen_q + (64'(n) << 3);
        pad_done_d = in_last && n < 4'(BYTES);
      end
      PAD: begin
        en_d = 1'b1;
        data_d = pad_done_q ? '0 : pw;
        pad_done_d = 1'b1;
      end
      LEN: begin
        en_d = 1'b1;
        data_d = addr_q == 4'(LEN_ADDR_HI) ? len_hi : len_lo;
      end
      HOLD: if (block_done) begin
        state_d = last_q ? LOAD : resume_q;
        if (last_q) begin
          bitlen_d = '0;
          pad_done_d = 1'b0;
          addr_d = '0;
          last_d = 1'b0;
        end
      end
      default: ;
    endcase
    follow = (state_q == PAD || (state_q == LOAD && in_last)) ? PAD : LOAD;
    if (en_d) begin
      addr_d = addr_q + 4'd1;
      if (addr_q == 4'(BLOCK_WORDS - 1)) begin
        state_d = HOLD;
        resume_d = follow;
        last_d = state_q == LEN;
      end else begin
        state_d = state_q == LEN ? LEN : (addr_q == 4'(LEN_ADDR_HI - 1) && pad_done_d) ? LEN : follow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      resume_q <= LOAD;
      addr_q <= '0;
      bitlen_q <= '0;
      pad_done_q <= 1'b0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      en_q <= 1'b0;
      maddr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      resume_q <= resume_d;
      addr_q <= addr_d;
      bitlen_q <= bitlen_d;
      pad_done_q <= pad_done_d;
      last_q <= last_d;
      valid_q <= valid_d;
      en_q <= en_d;
      maddr_q <= maddr_d;
      data_q <= data_d;
    end
  end

  assign in_ready = state_q == LOAD;
  assign mem_en_write = en_q;
  assign mem_addr_write = maddr_q;
  assign mem_data_in = data_q;
  assign block_valid = valid_q;
  assign block_last = last_q;
endmodule
